// File: rtl/psram_clk_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : psram_clk_gen_if
// Description : Control/status bundle between a requester and psram_clk_gen.
// Revision    : 1.0 - initial release
// ============================================================================
interface psram_clk_gen_if #(
    parameter int DIV_W = 4,
    parameter int CNT_W = 8
);
    logic             start;
    logic             stop;
    logic [DIV_W-1:0] div;
    logic [CNT_W-1:0] burst_len;
    logic             clk_q;
    logic             rise_stb;
    logic             fall_stb;
    logic             busy;
    logic             done;

    modport master (
        output start, stop, div, burst_len,
        input  clk_q, rise_stb, fall_stb, busy, done
    );

    modport slave (
        input  start, stop, div, burst_len,
        output clk_q, rise_stb, fall_stb, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/psram_clk_gen.sv
`default_nettype none
// ============================================================================
// Module      : psram_clk_gen
// Description : Registered PSRAM clock generator, free-run or fixed burst.
// Revision    : 1.0 - initial release
// ============================================================================
module psram_clk_gen #(
    parameter int DIV_W = 4,
    parameter int CNT_W = 8
) (
    input  wire logic      clk,
    input  wire logic      rst_n,
    psram_clk_gen_if.slave bus
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_HIGH = 2'd1;
    localparam logic [1:0] c_ST_LOW  = 2'd2;

    logic [1:0]       r_state;
    logic [DIV_W-1:0] r_hc;
    logic [DIV_W-1:0] r_div;
    logic [CNT_W-1:0] r_cnt;
    logic             r_stop_pend;
    logic             r_clk_q;
    logic             r_rise;
    logic             r_fall;
    logic             r_busy;
    logic             r_done;
    logic             w_last_burst;

    // A zero burst count means free-run, so only a count of exactly one ends it.
    assign w_last_burst = (r_cnt == CNT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_ST_IDLE;
            r_hc        <= '0;
            r_div       <= '0;
            r_cnt       <= '0;
            r_stop_pend <= 1'b0;
            r_clk_q     <= 1'b0;
            r_rise      <= 1'b0;
            r_fall      <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    r_done <= 1'b0;
                    r_rise <= 1'b0;
                    r_fall <= 1'b0;
                    if (bus.start) begin
                        r_div   <= bus.div;
                        r_cnt   <= bus.burst_len;
                        r_hc    <= bus.div;
                        r_state <= c_ST_HIGH;
                        r_clk_q <= 1'b1;
                        r_rise  <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                c_ST_HIGH: begin
                    r_rise <= 1'b0;
                    if (bus.stop) begin
                        r_stop_pend <= 1'b1;
                    end
                    if (r_hc == '0) begin
                        r_hc    <= r_div;
                        r_state <= c_ST_LOW;
                        r_clk_q <= 1'b0;
                        r_fall  <= 1'b1;
                    end else begin
                        r_hc <= r_hc - 1'b1;
                    end
                end
                c_ST_LOW: begin
                    r_fall <= 1'b0;
                    if (r_hc != '0) begin
                        r_hc <= r_hc - 1'b1;
                        if (bus.stop) begin
                            r_stop_pend <= 1'b1;
                        end
                    end else if (r_stop_pend || w_last_burst) begin
                        // Period boundary: only here may the run end cleanly.
                        r_state     <= c_ST_IDLE;
                        r_clk_q     <= 1'b0;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                        r_stop_pend <= 1'b0;
                    end else begin
                        if (bus.stop) begin
                            r_stop_pend <= 1'b1;
                        end
                        if (r_cnt != '0) begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                        r_hc    <= r_div;
                        r_state <= c_ST_HIGH;
                        r_clk_q <= 1'b1;
                        r_rise  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= c_ST_IDLE;
                    r_clk_q     <= 1'b0;
                    r_rise      <= 1'b0;
                    r_fall      <= 1'b0;
                    r_busy      <= 1'b0;
                    r_done      <= 1'b0;
                    r_stop_pend <= 1'b0;
                end
            endcase
        end
    end

    assign bus.clk_q    = r_clk_q;
    assign bus.rise_stb = r_rise;
    assign bus.fall_stb = r_fall;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;

endmodule
`default_nettype wire

// File: tb/tb_psram_clk_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_psram_clk_gen
// Description : Self-checking bench for psram_clk_gen with arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_psram_clk_gen;

    localparam int c_DIV_W = 4;
    localparam int c_CNT_W = 8;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    psram_clk_gen_if #(.DIV_W(c_DIV_W), .CNT_W(c_CNT_W)) bus ();

    psram_clk_gen #(.DIV_W(c_DIV_W), .CNT_W(c_CNT_W)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] observed();
        return {bus.clk_q, bus.rise_stb, bus.fall_stb, bus.busy, bus.done};
    endfunction

    task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed={clk_q,rise,fall,busy,done}=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Number of output periods a run produces. A stop seen in busy cycle t is
    // honoured at the first period end strictly after t.
    function automatic int n_periods(input int d, input int b, input int t);
        int p2;
        int ns;
        p2 = 2 * (d + 1);
        ns = (t >= 1) ? (t + p2) / p2 : 0;
        if (b == 0) return ns;
        if (ns == 0) return b;
        return (ns < b) ? ns : b;
    endfunction

    // Expected outputs o cycles after the start cycle of a run with n periods.
    function automatic logic [4:0] model(input int o, input int n, input int d);
        int p;
        int ph;
        p = d + 1;
        if (o >= 1 && o <= 2 * n * p) begin
            ph = (o - 1) % (2 * p);
            return {ph < p, ph == 0, ph == p, 1'b1, 1'b0};
        end
        if (o == 2 * n * p + 1) return 5'b00001;
        return 5'b00000;
    endfunction

    // Starts a run in the current cycle; returns in its done cycle.
    // t = cycle of a stop pulse (-1 none), j = cycle of an ignored start.
    task automatic run_case(input string tag, input int d, input int b,
                            input int t, input int j, input int jd);
        int n;
        n = n_periods(d, b, t);
        for (int c = 0; c <= 2 * n * (d + 1); c++) begin
            bus.start     = (c == 0) || (c == j);
            bus.stop      = (c == t);
            bus.div       = (c == 0) ? c_DIV_W'(d) : (c == j) ? c_DIV_W'(jd) : c_DIV_W'($urandom);
            bus.burst_len = (c == 0) ? c_CNT_W'(b) : c_CNT_W'($urandom_range(0, 7));
            tick();
            chk($sformatf("%s d=%0d b=%0d t=%0d j=%0d cyc=%0d", tag, d, b, t, j, c + 1),
                observed(), model(c + 1, n, d));
        end
        bus.start = 1'b0;
        bus.stop  = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            bus.start = 1'b0;
            bus.stop  = 1'($urandom);
            bus.div   = c_DIV_W'($urandom);
            tick();
            chk("idle", observed(), 5'b00000);
        end
        bus.stop = 1'b0;
    endtask

    initial begin
        int d;
        int b;
        int t;
        int j;
        int n;
        n_checks      = 0;
        n_errors      = 0;
        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.stop      = 1'b0;
        bus.div       = '0;
        bus.burst_len = '0;
        tick();
        chk("reset_state", observed(), 5'b00000);
        tick();
        rst_n = 1'b1;
        idle_cycles(2);

        run_case("burst3_div0", 0, 3, -1, -1, 0);
        idle_cycles(1);
        run_case("burst1_div2", 2, 1, -1, -1, 0);
        idle_cycles(2);
        run_case("freerun_stop", 1, 0, 2, -1, 0);
        idle_cycles(3);
        run_case("ignored_start", 0, 2, -1, 2, 3);
        run_case("back_to_back_maxdiv", 15, 1, -1, -1, 0);
        run_case("start_stop_together", 1, 2, 0, -1, 0);
        run_case("stop_last_period", 2, 2, 7, -1, 0);
        idle_cycles(1);

        // Reset in the middle of a high phase.
        bus.start     = 1'b1;
        bus.div       = 4'd3;
        bus.burst_len = 8'd4;
        tick();
        bus.start = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        chk("async_reset_mid_run", observed(), 5'b00000);
        tick();
        chk("reset_no_done", observed(), 5'b00000);
        rst_n = 1'b1;
        tick();
        chk("after_release", observed(), 5'b00000);
        run_case("post_reset", 0, 1, -1, -1, 0);
        idle_cycles(1);

        for (int i = 0; i < 30; i++) begin
            d = $urandom_range(0, 15);
            b = $urandom_range(0, 4);
            if (b == 0) t = $urandom_range(1, 6 * (d + 1));
            else if ($urandom_range(0, 1) == 1) t = $urandom_range(0, 2 * b * (d + 1));
            else t = -1;
            n = n_periods(d, b, t);
            j = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 2 * n * (d + 1)) : -1;
            run_case("random", d, b, t, j, $urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) idle_cycles($urandom_range(1, 3));
        end
        idle_cycles(1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
